zone_led_tx: RTL
================

# zone_led_tx

Frame-level backlight output stage, directly downstream of the 360-zone dimming block. It captures each zone value as it is produced (`flag_done`/`cnt_360`/`buf_360_flatted`) into a ping-pong zone buffer. On every frame sync it swaps banks and serially shifts the completed frame of 360 8-bit zone levels to the MiniLED driver chain, followed by a latch pulse.

## Interface
- `N_ZONES`, 360: zones per frame.
- `DW`, 8: bits per zone value.
- `CLK_DIV`, 2: pixel clocks per SCLK half-period; legal range ≥1.
- `LATCH_CYC`, 4: width of the latch pulse, in pixel clocks.

- `i_pix_clk`  in  1: pixel clock; the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `zone_valid`  in  1: one-cycle strobe; the zone value is valid (connects to `flag_done`).
- `zone_idx`  in  9: zone index 0..359 (connects to `cnt_360`).
- `zone_val`  in  DW: zone backlight level (connects to `buf_360_flatted`).
- `frame_sync`  in  1: frame sync level (connects to `r_Vsync_0`); the rising edge is used.
- `o_sclk`  out  1: serial clock to the LED driver.
- `o_sdata`  out  1: serial data, MSB first.
- `o_latch`  out  1: latch/load strobe to the LED driver.
- `o_busy`  out  1: high while a frame is being transmitted.
- `o_overrun`  out  1: one-cycle pulse when a frame sync arrives while busy.

## Operation
**Write side**
- On `zone_valid`, write `zone_val` to the write bank at address `zone_idx`.
- Ignore any `zone_idx` ≥ `N_ZONES`; the write is dropped.
- A repeated index overwrites the earlier value; the last write wins.

**Bank swap**
- A rising edge of `frame_sync` is detected by a registered compare against the previous `frame_sync` value.
- If the FSM is in IDLE on the edge cycle, toggle `wr_bank` and start transmission from the bank just completed.
- If the FSM is busy on the edge cycle, do not swap. Pulse `o_overrun` and keep writing into the same bank. The next frame overwrites it, and the in-flight transmission is not disturbed.
- If `zone_valid` and the swap happen in the same cycle, the write goes to the old bank, before the toggle.

**TX FSM**
- IDLE: `o_sclk`=0, `o_latch`=0, `o_busy`=0. Move to RD on a swap.
- RD: issue the RAM read for `tx_idx`. Move to LD.
- LD: load the RAM read data into the shift register. Set `bit_cnt`=DW-1. Move to SHIFT.
- SHIFT: `o_sdata` = shift register MSB. Each half-period lasts `CLK_DIV` cycles.
  - Low phase, then `o_sclk` rises, then high phase, then `o_sclk` falls, and the register shifts left.
  - After the falling edge of the last bit: if `tx_idx` = `N_ZONES`-1, go to LATCH. Otherwise increment `tx_idx` and go to RD.
  - `o_sclk` stays low during RD/LD, so there is a gap of 2 cycles between bytes.
- LATCH: `o_latch`=1 for `LATCH_CYC` cycles, `o_sdata`=0. Then clear `tx_idx` and go to IDLE.
- `o_busy` = (state ≠ IDLE).

**Reset**
- Reset is asynchronous and can occur mid-transmission.
- All outputs go to 0, the FSM goes to IDLE, `wr_bank`=0, `tx_idx`=0 and the edge detector is cleared.
- RAM contents are not cleared, so the first frame after reset transmits undefined data.

## Timing
- A `frame_sync` rising edge sampled at cycle T sets `o_busy`=1 at T+2.
- `o_sdata` is valid at T+4, and the first `o_sclk` rise is at T+4+`CLK_DIV`.
- Data changes only while `o_sclk` is low. Driver setup and hold are each ≥ `CLK_DIV` cycles.
- Per zone: `2*DW*CLK_DIV` + 2 cycles. With defaults: 34 cycles per zone, 12240 cycles per frame plus `LATCH_CYC`. This fits well within the 800-line frame.
- `o_overrun` is high only in the cycle after the edge is detected.
- RAM read latency is 1 cycle; the read data is registered in LD.

## Structure
- Shared package `backlight_pkg`:
  - `N_ZONES`, `ZONE_IDX_W` (9) and `DW`.
  - TX state encoding: IDLE/RD/LD/SHIFT/LATCH.
- Sub-module `zone_dpram`: simple dual-port RAM with one write port and one read port.
  - Depth `2*N_ZONES`, width `DW`, synchronous read.
  - Address = {bank, idx}. `wr_bank` drives the write port and ~`wr_bank` drives the read port.
- The top level holds the edge detector, the TX FSM, the SCLK divider counter and the bit/zone counters.

## Test plan
- **Basic frame:** write zone i = i[7:0] for i = 0..359, then one sync edge.
  - Expect 360 bytes MSB first: 0x00, 0x01, … 0x67.
  - Expect exactly 2880 `o_sclk` rises, then `o_latch` high for 4 cycles.
- **Ping-pong:** frame A (all 0xAA), sync, then frame B (all 0x55) written during A's transmission, then sync after idle.
  - The first transmission is all 0xAA and the second is all 0x55, with no mixing.
- **Overrun:** raise sync again 100 cycles into a transmission.
  - Expect one `o_overrun` pulse and no bank swap.
  - The current frame completes unchanged; the next swap is taken at the next sync after IDLE.
- **Index bounds:** `zone_valid` with `zone_idx`=360 and 511, value 0xFF.
  - Expect no write; zone 0 keeps its value.
  - Zone 5 written twice (0x10, then 0x20) transmits 0x20.
- **Reset mid-transmission:** assert `rst` at byte 100, bit 3.
  - All outputs go to 0 at once and `o_busy`=0.
  - After release, a fresh frame and sync transmit correctly from zone 0.
- **Divider:** `CLK_DIV`=1 and `CLK_DIV`=3.
  - The SCLK period is 2 and 6 cycles respectively.
  - The first rise is at T+5 and T+7 respectively.

Source files
------------

// File: rtl/backlight_pkg.sv
// Shared definitions for the backlight output path.
//   N_ZONES    : zones per frame
//   ZONE_IDX_W : width of a zone index
//   DW         : bits per zone level
//   tx_state_t : transmit FSM encoding
package backlight_pkg;

    localparam int N_ZONES    = 360;
    localparam int ZONE_IDX_W = 9;
    localparam int DW         = 8;
    localparam int BIT_CNT_W  = $clog2(DW);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_RD    = 3'd1,
        TX_LD    = 3'd2,
        TX_SHIFT = 3'd3,
        TX_LATCH = 3'd4
    } tx_state_t;

    // Indices past the last zone come from a wrapping upstream counter and
    // must never reach the RAM.
    function automatic logic idx_in_range(input logic [ZONE_IDX_W-1:0] idx);
        return idx < ZONE_IDX_W'(N_ZONES);
    endfunction

endpackage

// File: rtl/zone_dpram.sv
// Ping-pong zone buffer: one write port, one synchronous read port.
// Ports:
//   i_clk      : clock
//   i_we       : write enable
//   i_wr_bank  : bank selected for writing
//   i_wr_idx   : zone index to write
//   i_wr_data  : zone level to write
//   i_re       : read enable
//   i_rd_bank  : bank selected for reading
//   i_rd_idx   : zone index to read
//   o_rd_data  : read data, valid the cycle after i_re
module zone_dpram
    import backlight_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic                  i_wr_bank,
    input  logic [ZONE_IDX_W-1:0] i_wr_idx,
    input  logic [DW-1:0]         i_wr_data,
    input  logic                  i_re,
    input  logic                  i_rd_bank,
    input  logic [ZONE_IDX_W-1:0] i_rd_idx,
    output logic [DW-1:0]         o_rd_data
);

    localparam int DEPTH = 2 * N_ZONES;
    localparam int AW    = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;

    // Logical address is {bank, idx}; bank 1 is packed directly after bank 0
    // so the array stays 2*N_ZONES deep instead of a full power of two.
    assign w_wr_addr = i_wr_bank ? AW'(N_ZONES) + AW'(i_wr_idx) : AW'(i_wr_idx);
    assign w_rd_addr = i_rd_bank ? AW'(N_ZONES) + AW'(i_rd_idx) : AW'(i_rd_idx);

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end
        if (i_re) begin
            o_rd_data <= r_mem[w_rd_addr];
        end
    end

endmodule

// File: rtl/zone_led_tx.sv
// Frame-level backlight output stage. Captures zone levels into a ping-pong
// buffer and, on each frame sync rising edge, shifts the completed frame out
// MSB first to the LED driver chain, followed by a latch pulse.
// Ports:
//   i_pix_clk  : pixel clock
//   rst        : asynchronous active-high reset
//   zone_valid : one-cycle strobe, zone_val is valid
//   zone_idx   : zone index 0..N_ZONES-1 (others ignored)
//   zone_val   : zone level
//   frame_sync : frame sync level, rising edge starts a frame
//   o_sclk     : serial clock
//   o_sdata    : serial data, MSB first
//   o_latch    : latch strobe, LATCH_CYC cycles wide
//   o_busy     : high while a frame is being sent
//   o_overrun  : one-cycle pulse on a sync edge that arrives while busy
//
// state    | meaning
// ---------+-------------------------------------------------------
// TX_IDLE  | waiting for a sync edge, all serial outputs low
// TX_RD    | RAM read issued for tx_idx
// TX_LD    | read data loaded into the shift register
// TX_SHIFT | DW bits sent, CLK_DIV cycles per SCLK half-period
// TX_LATCH | latch held high for LATCH_CYC cycles
module zone_led_tx
    import backlight_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int LATCH_CYC = 4
) (
    input  logic                  i_pix_clk,
    input  logic                  rst,
    input  logic                  zone_valid,
    input  logic [ZONE_IDX_W-1:0] zone_idx,
    input  logic [DW-1:0]         zone_val,
    input  logic                  frame_sync,
    output logic                  o_sclk,
    output logic                  o_sdata,
    output logic                  o_latch,
    output logic                  o_busy,
    output logic                  o_overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAT_W = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
    localparam logic [DIV_W-1:0]      DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0]      LAT_LOAD = LAT_W'(LATCH_CYC - 1);
    localparam logic [ZONE_IDX_W-1:0] LAST_IDX = ZONE_IDX_W'(N_ZONES - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LOAD = BIT_CNT_W'(DW - 1);

    tx_state_t             r_state;
    logic                  r_sync;
    logic                  r_sync_d;
    logic                  r_edge;
    logic                  r_wr_bank;
    logic [ZONE_IDX_W-1:0] r_tx_idx;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [DIV_W-1:0]      r_div;
    logic                  r_phase;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [DW-1:0]         r_shift;
    logic                  r_sclk;
    logic                  r_latch;
    logic                  r_busy;
    logic                  r_overrun;

    logic                  w_we;
    logic                  w_re;
    logic [DW-1:0]         w_rd_data;

    // A write landing in the swap cycle still sees the old r_wr_bank.
    assign w_we = zone_valid && idx_in_range(zone_idx);
    assign w_re = (r_state == TX_RD);

    zone_dpram u_ram (
        .i_clk     (i_pix_clk),
        .i_we      (w_we),
        .i_wr_bank (r_wr_bank),
        .i_wr_idx  (zone_idx),
        .i_wr_data (zone_val),
        .i_re      (w_re),
        .i_rd_bank (~r_wr_bank),
        .i_rd_idx  (r_tx_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_pix_clk or posedge rst) begin
        if (rst) begin
            r_state   <= TX_IDLE;
            r_sync    <= 1'b0;
            r_sync_d  <= 1'b0;
            r_edge    <= 1'b0;
            r_wr_bank <= 1'b0;
            r_tx_idx  <= '0;
            r_bit_cnt <= '0;
            r_div     <= '0;
            r_phase   <= 1'b0;
            r_lat_cnt <= '0;
            r_shift   <= '0;
            r_sclk    <= 1'b0;
            r_latch   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sync    <= frame_sync;
            r_sync_d  <= r_sync;
            r_edge    <= r_sync & ~r_sync_d;
            // Busy edges are dropped: the bank keeps filling and the next
            // frame overwrites it.
            r_overrun <= r_edge && (r_state != TX_IDLE);

            case (r_state)
                TX_IDLE: begin
                    if (r_edge) begin
                        r_wr_bank <= ~r_wr_bank;
                        r_busy    <= 1'b1;
                        r_state   <= TX_RD;
                    end
                end
                TX_RD: begin
                    r_state <= TX_LD;
                end
                TX_LD: begin
                    r_shift   <= w_rd_data;
                    r_bit_cnt <= BIT_LOAD;
                    r_div     <= DIV_LOAD;
                    r_phase   <= 1'b0;
                    r_state   <= TX_SHIFT;
                end
                TX_SHIFT: begin
                    if (r_div == '0) begin
                        r_div <= DIV_LOAD;
                        if (!r_phase) begin
                            r_sclk  <= 1'b1;
                            r_phase <= 1'b1;
                        end else begin
                            // Data only moves on the falling edge, giving a
                            // full half-period of setup and hold.
                            r_sclk  <= 1'b0;
                            r_phase <= 1'b0;
                            r_shift <= {r_shift[DW-2:0], 1'b0};
                            if (r_bit_cnt == '0) begin
                                if (r_tx_idx == LAST_IDX) begin
                                    r_latch   <= 1'b1;
                                    r_lat_cnt <= LAT_LOAD;
                                    r_state   <= TX_LATCH;
                                end else begin
                                    r_tx_idx <= r_tx_idx + 1'b1;
                                    r_state  <= TX_RD;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 1'b1;
                            end
                        end
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                TX_LATCH: begin
                    if (r_lat_cnt == '0) begin
                        r_latch  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_tx_idx <= '0;
                        r_state  <= TX_IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    // The shift register is empty after the last bit, so o_sdata is low
    // during RD/LD of the next byte and throughout LATCH.
    assign o_sclk    = r_sclk;
    assign o_sdata   = r_shift[DW-1];
    assign o_latch   = r_latch;
    assign o_busy    = r_busy;
    assign o_overrun = r_overrun;

endmodule
